// File: rtl/mile_display_driver.sv
// Distance-to-display driver: clamps the tenths-of-a-mile count, converts it to BCD
// with a one-shift-per-cycle double-dabble engine and scans a 4-digit "XXX.X" display.
module mile_display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int SAT_VALUE   = 9999
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [13:0] mileCounter,
    output logic [3:0]  anode,
    output logic [6:0]  sevenSeg,
    output logic        decimalPoint,
    output logic        busy
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RW-1:0] REF_MAX = RW'(REFRESH_DIV - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] SHIFT  = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    logic [1:0]    state;
    logic [13:0]   clampVal;
    logic [13:0]   sampledVal;
    logic [13:0]   shiftBin;
    logic [15:0]   bcdScratch;
    logic [15:0]   bcdAdj;
    logic [15:0]   dispBcd;
    logic [3:0]    iterCnt;
    logic          pending;
    logic [RW-1:0] refreshCnt;
    logic [1:0]    scanIdx;
    logic [3:0]    curDigit;
    logic [6:0]    segCode;
    logic          blankDigit;

    always_comb begin
        clampVal = (mileCounter > 14'(SAT_VALUE)) ? 14'(SAT_VALUE) : mileCounter;
    end

    // Add-3 correction on every nibble before the shift
    always_comb begin
        bcdAdj = bcdScratch;
        for (int i = 0; i < 4; i++) begin
            if (bcdScratch[4*i +: 4] >= 4'd5)
                bcdAdj[4*i +: 4] = bcdScratch[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            sampledVal <= '0;
            shiftBin   <= '0;
            bcdScratch <= '0;
            iterCnt    <= '0;
            pending    <= 1'b0;
            dispBcd    <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clampVal != sampledVal)
                        state <= LOAD;
                end
                LOAD: begin
                    shiftBin   <= clampVal;
                    sampledVal <= clampVal;
                    bcdScratch <= '0;
                    iterCnt    <= 4'd14;
                    busy       <= 1'b1;
                    state      <= SHIFT;
                end
                SHIFT: begin
                    bcdScratch <= {bcdAdj[14:0], shiftBin[13]};
                    shiftBin   <= {shiftBin[12:0], 1'b0};
                    iterCnt    <= iterCnt - 4'd1;
                    if (iterCnt == 4'd1)
                        state <= COMMIT;
                    if (clampVal != sampledVal)
                        pending <= 1'b1;
                end
                default: begin
                    // Display register only ever sees a finished conversion
                    dispBcd <= bcdScratch;
                    busy    <= 1'b0;
                    pending <= 1'b0;
                    state   <= (pending || (clampVal != sampledVal)) ? LOAD : IDLE;
                end
            endcase
        end
    end

    always_comb begin
        case (scanIdx)
            2'd0:    curDigit = dispBcd[3:0];
            2'd1:    curDigit = dispBcd[7:4];
            2'd2:    curDigit = dispBcd[11:8];
            default: curDigit = dispBcd[15:12];
        endcase
        blankDigit = ((scanIdx == 2'd3) && (dispBcd[15:12] == 4'd0)) ||
                     ((scanIdx == 2'd2) && (dispBcd[15:8] == 8'd0));
    end

    always_comb begin
        case (curDigit)
            4'd0:    segCode = 7'b1000000;
            4'd1:    segCode = 7'b1111001;
            4'd2:    segCode = 7'b0100100;
            4'd3:    segCode = 7'b0110000;
            4'd4:    segCode = 7'b0011001;
            4'd5:    segCode = 7'b0010010;
            4'd6:    segCode = 7'b0000010;
            4'd7:    segCode = 7'b1111000;
            4'd8:    segCode = 7'b0000000;
            4'd9:    segCode = 7'b0010000;
            default: segCode = 7'b1111111;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            refreshCnt   <= '0;
            scanIdx      <= 2'd0;
            anode        <= 4'b1111;
            sevenSeg     <= 7'b1111111;
            decimalPoint <= 1'b1;
        end else begin
            if (refreshCnt == REF_MAX) begin
                refreshCnt <= '0;
                scanIdx    <= scanIdx + 2'd1;
            end else begin
                refreshCnt <= refreshCnt + 1'b1;
            end
            anode        <= ~(4'b0001 << scanIdx);
            sevenSeg     <= blankDigit ? 7'b1111111 : segCode;
            decimalPoint <= (scanIdx != 2'd1);
        end
    end

endmodule

// File: tb/tb_mile_display_driver.sv
// Randomized scoreboard bench for mile_display_driver: expected display values are
// queued at stimulus time and checked by a monitor that decodes the scanned digits.
module tb_mile_display_driver;

    localparam int RD  = 4;
    localparam int SAT = 9999;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [13:0] mileCounter = '0;
    logic [3:0]  anode;
    logic [6:0]  sevenSeg;
    logic        decimalPoint;
    logic        busy;

    always #5 CLK = ~CLK;

    mile_display_driver #(.REFRESH_DIV(RD), .SAT_VALUE(SAT)) dut (
        .CLK(CLK), .RESET(RESET), .mileCounter(mileCounter),
        .anode(anode), .sevenSeg(sevenSeg), .decimalPoint(decimalPoint), .busy(busy)
    );

    int nCmp = 0;
    int nErr = 0;
    int expQ[$];
    int seen[4];
    int lastVal = 0;

    // 0-9 for a digit, 10 for blank, 15 for an illegal pattern
    function automatic int segDecode(input logic [6:0] s);
        case (s)
            7'b1000000: return 0;
            7'b1111001: return 1;
            7'b0100100: return 2;
            7'b0110000: return 3;
            7'b0011001: return 4;
            7'b0010010: return 5;
            7'b0000010: return 6;
            7'b1111000: return 7;
            7'b0000000: return 8;
            7'b0010000: return 9;
            7'b1111111: return 10;
            default:    return 15;
        endcase
    endfunction

    function automatic int expDigit(input int v, input int pos);
        case (pos)
            0:       return v % 10;
            1:       return (v / 10) % 10;
            2:       return (v < 100) ? 10 : (v / 100) % 10;
            default: return (v < 1000) ? 10 : v / 1000;
        endcase
    endfunction

    function automatic int clampM(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nCmp++;
        if (act != exp) begin
            nErr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: busy run lengths, scan legality, and settled display vs. scoreboard
    initial begin
        int hold = 2, busyRun = 0, settle = 0, anRun = 0, idx = -1, prevIdx = -1, d, v;
        bit armed = 0;
        logic prevBusy = 1'b0;
        logic [3:0] prevAn = 4'hF;
        for (int p = 0; p < 4; p++) seen[p] = 15;
        forever begin
            @(negedge CLK);
            if (RESET) hold = 2;
            if (hold > 0) begin
                hold--;
                busyRun = 0; settle = 0; armed = 0; anRun = 0;
                prevBusy = 1'b0; prevAn = 4'hF; prevIdx = -1;
                for (int p = 0; p < 4; p++) seen[p] = 15;
            end else begin
                if (busy) begin
                    busyRun++;
                    settle = 0;
                end else begin
                    if (prevBusy) begin
                        check("busy_len", busyRun, 15);
                        busyRun = 0;
                        armed = 1;
                        settle = 0;
                    end
                    if (armed) begin
                        settle++;
                        if (settle == 4*RD + 2) begin
                            armed = 0;
                            check("queue_nonempty", int'(expQ.size() > 0), 1);
                            if (expQ.size() > 0) begin
                                v = expQ.pop_front();
                                for (int p = 0; p < 4; p++)
                                    check($sformatf("digit%0d_of_%0d", p, v), seen[p], expDigit(v, p));
                            end
                        end
                    end
                end
                prevBusy = busy;

                if (anode != 4'hF) begin
                    case (anode)
                        4'b1110: idx = 0;
                        4'b1101: idx = 1;
                        4'b1011: idx = 2;
                        4'b0111: idx = 3;
                        default: idx = -1;
                    endcase
                    check("anode_onehot", int'(idx >= 0), 1);
                    if (idx >= 0) begin
                        check("dp", int'(decimalPoint), (idx == 1) ? 0 : 1);
                        d = segDecode(sevenSeg);
                        check("seg_legal", int'(d != 15), 1);
                        seen[idx] = d;
                    end
                    if (anode == prevAn) anRun++;
                    else begin
                        if (prevAn != 4'hF) begin
                            check("scan_len", anRun, RD);
                            check("scan_order", idx, (prevIdx + 1) % 4);
                        end
                        anRun = 1;
                    end
                    prevAn = anode;
                    prevIdx = idx;
                end
            end
        end
    end

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check("drain_timeout", expQ.size(), 0);
        expQ.delete();
        repeat (2) @(posedge CLK);
        #1;
    endtask

    task automatic apply(input int v);
        if (clampM(v) != lastVal) begin
            expQ.push_back(clampM(v));
            lastVal = clampM(v);
        end
        mileCounter = 14'(v);
        waitDrain();
    endtask

    initial begin
        int n;
        RESET = 1'b1;
        mileCounter = '0;
        repeat (3) begin
            @(posedge CLK); #1;
            check("rst_anode", int'(anode), 4'hF);
            check("rst_seg", int'(sevenSeg), 7'h7F);
            check("rst_dp", int'(decimalPoint), 1);
            check("rst_busy", int'(busy), 0);
        end
        RESET = 1'b0;
        repeat (4*RD + 4) @(posedge CLK);
        #1;
        for (int p = 0; p < 4; p++) check($sformatf("zero_digit%0d", p), seen[p], expDigit(0, p));
        check("zero_busy", int'(busy), 0);
        lastVal = 0;

        apply(5);
        apply(125);
        apply(16383);
        apply(10000);
        apply(0);

        // Back-to-back changes while busy: only the final value must be shown
        mileCounter = 14'd5;
        n = 0;
        do begin @(posedge CLK); #1; n++; end while (!busy && n < 20);
        check("burst_busy", int'(busy), 1);
        mileCounter = 14'd10;
        @(posedge CLK); #1;
        mileCounter = 14'd15;
        expQ.push_back(15);
        lastVal = 15;
        waitDrain();

        // Reset landing on the 7th shift of a conversion to 9999
        mileCounter = 14'd9999;
        expQ.push_back(9999);
        lastVal = 9999;
        repeat (8) @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK); #1;
        check("midrst_anode", int'(anode), 4'hF);
        check("midrst_seg", int'(sevenSeg), 7'h7F);
        check("midrst_dp", int'(decimalPoint), 1);
        check("midrst_busy", int'(busy), 0);
        RESET = 1'b0;
        waitDrain();

        repeat (20) begin
            if ($urandom_range(0, 3) == 0) apply(int'($urandom_range(9990, 16383)));
            else apply(int'($urandom_range(0, 9999)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule

// File: doc/mile_display_driver.md
Name: mile_display_driver

Overview:
- Consumes the 14-bit distance count from the step-to-distance block. The count is in tenths of a mile and advances by 5 per 0.5 mi.
- Converts the count to 4 BCD digits with a sequential double-dabble engine, one shift per cycle.
- Drives the board's 4-digit multiplexed seven-segment display as "XXX.X" (a fixed decimal point after the tens digit).
- Sits between the distance counter and the display pins.

Parameters:
- REFRESH_DIV, 100000, CLK cycles each digit stays lit (1 ms at 100 MHz); legal values are 2 or more.
- SAT_VALUE, 9999, clamp applied to mileCounter before conversion; the display shows at most 999.9.

Ports:
- CLK  input  1  system clock, all logic on rising edge
- RESET  input  1  synchronous, active-high reset
- mileCounter  input  14  distance in tenths of a mile, unsigned
- anode  output  4  digit enables, active-low; bit0 is the rightmost digit (tenths)
- sevenSeg  output  7  segments {g,f,e,d,c,b,a}, active-low
- decimalPoint  output  1  active-low; lit only while digit 1 is enabled
- busy  output  1  high while a BCD conversion is in progress

Behaviour:
- All outputs are registered.
- RESET (synchronous, active-high) puts everything in a known state:
  - anode=4'b1111, sevenSeg=7'b1111111, decimalPoint=1, busy=0
  - display BCD register=0000, sampled value=0, refresh counter=0, scan index=0, state=IDLE, pending=0
- RESET asserted mid-conversion aborts the conversion immediately; the display register is not updated.
- Clamp: clampVal = (mileCounter > SAT_VALUE) ? SAT_VALUE : mileCounter.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE: if clampVal != sampled value, go to LOAD.
  - LOAD (1 cycle): latch clampVal into the shift register and sampled value; clear the BCD scratch; set the iteration counter to 14; busy=1.
  - SHIFT (14 cycles): each cycle, add 3 to every BCD nibble >=5, then shift {bcd,bin} left by 1 and decrement the counter. At count 0, go to COMMIT.
  - COMMIT (1 cycle): copy the scratch into the display register, then busy=0. Go to LOAD if pending or clampVal != sampled value, otherwise go to IDLE; clear pending.
- Latency: a mileCounter change sampled in IDLE at edge N reaches the display register at edge N+16.
- Input changes while busy set pending. Intermediate values may be skipped, but the final stable input is always displayed.
- Scan timing:
  - The refresh counter runs from 0 to REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→2→3→0.
  - anode is the one-hot-low of the scan index; it is updated on the same edge as sevenSeg and decimalPoint, with no blanking cycle.
- Segment encodings, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading-zero blanking:
  - Digit 3 is blanked (sevenSeg=1111111, anode still driven) when it is 0.
  - Digit 2 is blanked when digits 3 and 2 are both 0.
  - Digits 1 and 0 are always shown, so 0 displays as "0.0".
- Display content changes only in COMMIT, so the scan never shows a partially converted value.

Test Plan:
- Reset and hold 3 cycles, then release with mileCounter=0 → anode=1111 and sevenSeg=1111111 during reset. Afterwards the scan shows digit0="0", digit1="0" with decimalPoint=0, digits 2–3 blank; busy stays 0.
- REFRESH_DIV=4, mileCounter=5 → busy high for 15 cycles starting 1 edge after the change; display register updates at N+16. Scan shows "0.5": anode 1110 with 0010010, 1101 with 1000000 and dp=0, 1011 blank, 0111 blank, each held 4 cycles.
- mileCounter=125 → digits read blank, 1, 2., 5; decimalPoint=0 only while anode=1101.
- mileCounter=16383 (saturation) → display reads 9,9,9.,9 (999.9).
- Sequence 5→10→15, one cycle apart, all changes while busy → pending set, a second conversion runs back to back, and the final display reads "1.5"; "1.0" is never committed if skipped. No glitch in the digits being scanned.
- RESET pulsed at SHIFT iteration 7 of a conversion to 9999 → all outputs go to reset values on the next edge and busy=0. After release with mileCounter=9999, a fresh conversion completes in 16 cycles and shows "999.9".
